// File: rtl/reg_file_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb_pkg
// Description : Default sizing constants and select-width helper shared by
//               the scoreboarded register file and its read ports.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_sb_pkg;

    localparam int RF_WIDTH = 4;
    localparam int RF_DEPTH = 4;
    localparam int RF_NREAD = 2;

    // Select width for a register file of the given depth; never below one
    // bit so a two-entry file still has a usable select.
    function automatic int rf_aw(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb_rd_port
// Description : One combinational read port of the scoreboarded register
//               file: register mux, zeroing of out-of-range selects and,
//               when REG_FILE_SB_BYPASS_EN is defined, same-cycle forwarding
//               of the writeback data and post-edge busy value.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb_rd_port
    import reg_file_sb_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = rf_aw(RF_DEPTH)
) (
    input  logic [DEPTH*WIDTH-1:0] i_q_flat,
    input  logic [DEPTH-1:0]       i_b_vec,
    input  logic [AW-1:0]          i_sel,
`ifdef REG_FILE_SB_BYPASS_EN
    input  logic                   i_rst,
    input  logic                   i_we,
    input  logic [AW-1:0]          i_sel_w,
    input  logic [WIDTH-1:0]       i_data_in,
    input  logic                   i_rsv_en,
    input  logic [AW-1:0]          i_sel_rsv,
`endif
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_busy
);

    logic [WIDTH-1:0] w_data;
    logic             w_busy;

    // Register mux; a select matching no register leaves data and busy at 0.
    always_comb begin
        w_data = '0;
        w_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_sel == AW'(i)) begin
                w_data = i_q_flat[i*WIDTH +: WIDTH];
                w_busy = i_b_vec[i];
            end
        end
    end

`ifdef REG_FILE_SB_BYPASS_EN
    logic w_sel_ok;
    logic w_hit;

    // Flag whether this port selects an existing register.
    always_comb begin
        w_sel_ok = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_sel == AW'(i)) begin
                w_sel_ok = 1'b1;
            end
        end
    end

    // Forward writeback data and the busy value the register will hold after
    // the edge: a write clears busy unless the same register is reserved.
    always_comb begin
        w_hit  = !i_rst && i_we && w_sel_ok && (i_sel_w == i_sel);
        o_data = w_hit ? i_data_in : w_data;
        o_busy = w_hit ? (i_rsv_en && (i_sel_rsv == i_sel)) : w_busy;
    end
`else
    assign o_data = w_data;
    assign o_busy = w_busy;
`endif

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Parametrised scoreboarded register file. Each register holds
//               a data word and a busy bit; the issue stage reserves a
//               destination (busy=1), writeback stores data and clears busy.
//               Reserve wins over a same-cycle write to the same register.
//               Optional macro REG_FILE_SB_BYPASS_EN forwards writeback data
//               to matching read ports in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter  int WIDTH = RF_WIDTH,
    parameter  int DEPTH = RF_DEPTH,
    parameter  int NREAD = RF_NREAD,
    localparam int AW    = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   WE,
    input  logic [AW-1:0]          SEL_W,
    input  logic [WIDTH-1:0]       DATA_IN,
    input  logic                   RSV_EN,
    input  logic [AW-1:0]          SEL_RSV,
    input  logic [NREAD*AW-1:0]    SEL_R,
    output logic [NREAD*WIDTH-1:0] OUT_R,
    output logic [NREAD-1:0]       BUSY_R,
    output logic [DEPTH-1:0]       BUSY_VEC
);

    logic [WIDTH-1:0]       r_q [DEPTH];
    logic [DEPTH-1:0]       r_b;
    logic [DEPTH*WIDTH-1:0] w_q_flat;

    // Data storage: per-register write decode; out-of-range selects hit nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WE && (SEL_W == AW'(i))) begin
                    r_q[i] <= DATA_IN;
                end
            end
        end
    end

    // Scoreboard: reserve sets busy and takes priority over a writeback clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_b <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (RSV_EN && (SEL_RSV == AW'(i))) begin
                    r_b[i] <= 1'b1;
                end else if (WE && (SEL_W == AW'(i))) begin
                    r_b[i] <= 1'b0;
                end
            end
        end
    end

    assign BUSY_VEC = r_b;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_flat
            assign w_q_flat[i*WIDTH +: WIDTH] = r_q[i];
        end

        for (genvar k = 0; k < NREAD; k++) begin : g_rd
            reg_file_sb_rd_port #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_rd_port (
                .i_q_flat  (w_q_flat),
                .i_b_vec   (r_b),
                .i_sel     (SEL_R[k*AW +: AW]),
`ifdef REG_FILE_SB_BYPASS_EN
                .i_rst     (rst),
                .i_we      (WE),
                .i_sel_w   (SEL_W),
                .i_data_in (DATA_IN),
                .i_rsv_en  (RSV_EN),
                .i_sel_rsv (SEL_RSV),
`endif
                .o_data    (OUT_R[k*WIDTH +: WIDTH]),
                .o_busy    (BUSY_R[k])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Self-checking bench for reg_file_sb. Instance A uses the
//               default 4x4, two-port sizing and is driven from a vector
//               table plus a same-cycle read/write sequence. Instance B is
//               8-bit, 6-deep, three ports and runs randomised traffic
//               against an array-based reference model.
//               Honours REG_FILE_SB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance A: 4 bits, 4 deep, 2 ports ----------------
    logic       rst_a, we_a, rsv_a;
    logic [1:0] sel_w_a, sel_rsv_a;
    logic [3:0] din_a;
    logic [3:0] sel_r_a;
    logic [7:0] out_a;
    logic [1:0] busy_a;
    logic [3:0] bv_a;

    reg_file_sb #(.WIDTH(4), .DEPTH(4), .NREAD(2)) dut_a (
        .clk(clk), .rst(rst_a), .WE(we_a), .SEL_W(sel_w_a), .DATA_IN(din_a),
        .RSV_EN(rsv_a), .SEL_RSV(sel_rsv_a), .SEL_R(sel_r_a),
        .OUT_R(out_a), .BUSY_R(busy_a), .BUSY_VEC(bv_a)
    );

    // ---------------- instance B: 8 bits, 6 deep, 3 ports ----------------
    logic        rst_b, we_b, rsv_b;
    logic [2:0]  sel_w_b, sel_rsv_b;
    logic [7:0]  din_b;
    logic [8:0]  sel_r_b;
    logic [23:0] out_b;
    logic [2:0]  busy_b;
    logic [5:0]  bv_b;

    reg_file_sb #(.WIDTH(8), .DEPTH(6), .NREAD(3)) dut_b (
        .clk(clk), .rst(rst_b), .WE(we_b), .SEL_W(sel_w_b), .DATA_IN(din_b),
        .RSV_EN(rsv_b), .SEL_RSV(sel_rsv_b), .SEL_R(sel_r_b),
        .OUT_R(out_b), .BUSY_R(busy_b), .BUSY_VEC(bv_b)
    );

    // Reference model for instance B: plain arrays of contents and busy flags.
    int mq [6];
    bit mb [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every port and the busy vector of B against the model, taking
    // the current (pre-edge) inputs into account for the bypass case.
    task automatic check_b(input string tag);
        logic [5:0] ebv;
        for (int k = 0; k < 3; k++) begin
            int s;
            int ed;
            bit eb;
            s = int'(sel_r_b[k*3 +: 3]);
            if (s >= 6) begin
                ed = 0; eb = 0;
            end else if (BYP && !rst_b && we_b && int'(sel_w_b) == s) begin
                ed = int'(din_b);
                eb = rsv_b && int'(sel_rsv_b) == s;
            end else begin
                ed = mq[s]; eb = mb[s];
            end
            chk($sformatf("%s_out%0d", tag, k), 32'(out_b[k*8 +: 8]), 32'(ed));
            chk($sformatf("%s_busy%0d", tag, k), 32'(busy_b[k]), 32'(eb));
        end
        for (int i = 0; i < 6; i++) ebv[i] = mb[i];
        chk({tag, "_bv"}, 32'(bv_b), 32'(ebv));
    endtask

    // Advance the model by one edge using the inputs currently driven on B.
    task automatic model_edge_b();
        if (rst_b) begin
            for (int i = 0; i < 6; i++) begin mq[i] = 0; mb[i] = 0; end
        end else begin
            if (we_b && sel_w_b < 6) begin
                mq[sel_w_b] = int'(din_b);
                mb[sel_w_b] = 0;
            end
            if (rsv_b && sel_rsv_b < 6) mb[sel_rsv_b] = 1;
        end
    endtask

    task automatic idle_b();
        rst_b = 0; we_b = 0; rsv_b = 0;
    endtask

    typedef struct {
        logic       rst;
        logic       we;
        logic [1:0] sel_w;
        logic [3:0] din;
        logic       rsv;
        logic [1:0] sel_rsv;
        logic [1:0] s0;
        logic [1:0] s1;
        logic [3:0] e0;
        logic [3:0] e1;
        logic [3:0] ebv;
    } vec_t;

    vec_t tbl [13];

    initial begin
        // rst  we  sel_w din  rsv  sel_rsv s0 s1  e0  e1  busy_vec
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 2'd0, 2'd3, 4'h0, 4'h0, 4'b0000};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd2, 2'd2, 2'd0, 4'h0, 4'h0, 4'b0100};
        tbl[2]  = '{1'b0, 1'b1, 2'd2, 4'hA, 1'b0, 2'd0, 2'd2, 2'd0, 4'hA, 4'h0, 4'b0000};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 4'h5, 1'b1, 2'd1, 2'd1, 2'd2, 4'h5, 4'hA, 4'b0010};
        tbl[4]  = '{1'b0, 1'b1, 2'd3, 4'h2, 1'b0, 2'd0, 2'd3, 2'd1, 4'h2, 4'h5, 4'b0010};
        tbl[5]  = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b1, 2'd3, 2'd0, 2'd3, 4'hF, 4'h2, 4'b1010};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 2'd0, 2'd0, 4'hF, 4'hF, 4'b1011};
        tbl[7]  = '{1'b0, 1'b1, 2'd3, 4'h6, 1'b0, 2'd0, 2'd3, 2'd1, 4'h6, 4'h5, 4'b0011};
        tbl[8]  = '{1'b1, 1'b1, 2'd1, 4'h9, 1'b1, 2'd2, 2'd1, 2'd2, 4'h0, 4'h0, 4'b0000};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd0, 2'd0, 2'd1, 4'h0, 4'h0, 4'b0001};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 4'h0, 1'b1, 2'd1, 2'd0, 2'd1, 4'h0, 4'h0, 4'b0011};
        tbl[11] = '{1'b1, 1'b0, 2'd0, 4'h0, 1'b0, 2'd0, 2'd0, 2'd1, 4'h0, 4'h0, 4'b0000};
        tbl[12] = '{1'b0, 1'b1, 2'd0, 4'hF, 1'b0, 2'd0, 2'd0, 2'd1, 4'hF, 4'h0, 4'b0000};

        rst_a = 1; we_a = 0; rsv_a = 0; sel_w_a = 0; sel_rsv_a = 0; din_a = 0; sel_r_a = 0;
        rst_b = 1; we_b = 0; rsv_b = 0; sel_w_b = 0; sel_rsv_b = 0; din_b = 0; sel_r_b = 0;
        model_edge_b();
        tick();
        idle_b();

        // ---- instance A: vector table, each row checked after its edge ----
        for (int n = 0; n < 13; n++) begin
            rst_a = tbl[n].rst; we_a = tbl[n].we; sel_w_a = tbl[n].sel_w; din_a = tbl[n].din;
            rsv_a = tbl[n].rsv; sel_rsv_a = tbl[n].sel_rsv;
            sel_r_a = {tbl[n].s1, tbl[n].s0};
            tick();
            rst_a = 0; we_a = 0; rsv_a = 0;
            #1;
            chk($sformatf("a_row%0d_out0", n), 32'(out_a[3:0]), 32'(tbl[n].e0));
            chk($sformatf("a_row%0d_out1", n), 32'(out_a[7:4]), 32'(tbl[n].e1));
            chk($sformatf("a_row%0d_busy0", n), 32'(busy_a[0]), 32'(tbl[n].ebv[tbl[n].s0]));
            chk($sformatf("a_row%0d_busy1", n), 32'(busy_a[1]), 32'(tbl[n].ebv[tbl[n].s1]));
            chk($sformatf("a_row%0d_bv", n), 32'(bv_a), 32'(tbl[n].ebv));
        end

        // ---- instance A: same-cycle read of r3 while it is written ----
        we_a = 1; sel_w_a = 2'd3; din_a = 4'h2;
        tick();
        we_a = 0;
        sel_r_a = {2'd0, 2'd3};
        we_a = 1; sel_w_a = 2'd3; din_a = 4'h7; rsv_a = 1; sel_rsv_a = 2'd3;
        #1;
        chk("a_same_cycle_out", 32'(out_a[3:0]), BYP ? 32'h7 : 32'h2);
        chk("a_same_cycle_busy", 32'(busy_a[0]), BYP ? 32'h1 : 32'h0);
        chk("a_same_cycle_other_port", 32'(out_a[7:4]), 32'hF);
        chk("a_same_cycle_bv", 32'(bv_a), 32'h0);
        tick();
        we_a = 0; rsv_a = 0;
        #1;
        chk("a_next_cycle_out", 32'(out_a[3:0]), 32'h7);
        chk("a_next_cycle_busy", 32'(busy_a[0]), 32'h1);
        chk("a_next_cycle_bv", 32'(bv_a), 32'b1000);
        rst_a = 1;
        #1;
        chk("a_rst_in_cycle_out", 32'(out_a[3:0]), 32'h7);
        chk("a_rst_in_cycle_bv", 32'(bv_a), 32'b1000);
        tick();
        rst_a = 0;
        #1;
        chk("a_after_rst_out", 32'(out_a), 32'h0);
        chk("a_after_rst_bv", 32'(bv_a), 32'h0);

        // ---- instance B: out-of-range write and read ----
        we_b = 1; sel_w_b = 3'd7; din_b = 8'hAB; sel_r_b = {3'd1, 3'd0, 3'd6};
        #1;
        check_b("b_oor_pre");
        model_edge_b();
        tick();
        idle_b();
        sel_r_b = {3'd7, 3'd6, 3'd0};
        #1;
        check_b("b_oor_post");

        // ---- instance B: fill every register, read three distinct ones ----
        for (int i = 0; i < 6; i++) begin
            we_b = 1; sel_w_b = 3'(i); din_b = 8'(8'h30 + 8'(i * 17));
            model_edge_b();
            tick();
        end
        idle_b();
        sel_r_b = {3'd0, 3'd2, 3'd5};
        #1;
        check_b("b_distinct");
        chk("b_distinct_port0", 32'(out_b[7:0]), 32'h85);
        chk("b_distinct_port2", 32'(out_b[23:16]), 32'h30);

        // ---- instance B: randomised traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            rst_b     = ($urandom_range(0, 24) == 0);
            we_b      = 1'($urandom_range(0, 1));
            sel_w_b   = 3'($urandom_range(0, 7));
            din_b     = 8'($urandom);
            rsv_b     = 1'($urandom_range(0, 1));
            sel_rsv_b = ($urandom_range(0, 3) == 0) ? sel_w_b : 3'($urandom_range(0, 7));
            sel_r_b   = 9'($urandom);
            if ($urandom_range(0, 2) == 0) sel_r_b[2:0] = sel_w_b;
            #1;
            check_b($sformatf("b_rand%0d", n));
            model_edge_b();
            tick();
        end
        idle_b();
        #1;
        check_b("b_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
